// File: rtl/adsr_envelope_gen.sv
// ADSR envelope generator with built-in VCA: one instance per voice, level stepped by a
// programmable-rate tick, sample scaled by the current level with one cycle of latency.
module adsr_envelope_gen #(
    parameter int unsigned IN_W    = 16,
    parameter int unsigned LVL_W   = 16,
    parameter int unsigned PRESC_W = 16,
    localparam int unsigned OUT_W  = IN_W + 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               note_on_i,
    input  logic [IN_W-1:0]    sample_in_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic [LVL_W-1:0]   attack_step_i,
    input  logic [LVL_W-1:0]   decay_step_i,
    input  logic [LVL_W-1:0]   sustain_level_i,
    input  logic [LVL_W-1:0]   release_step_i,
    output logic [OUT_W-1:0]   sample_out_o,
    output logic [LVL_W-1:0]   env_level_o,
    output logic [2:0]         stage_o,
    output logic               active_o,
    output logic               env_done_o
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAttack  = 3'd1,
        StDecay   = 3'd2,
        StSustain = 3'd3,
        StRelease = 3'd4
    } stage_e;

    localparam logic [LVL_W-1:0] LvlMax = '1;

    stage_e               stage_q, stage_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [PRESC_W-1:0]   presc_cnt_q, presc_cnt_d;
    logic                 gate_q;
    logic                 env_done_q, env_done_d;
    logic [OUT_W-1:0]     sample_out_q, sample_out_d;

    logic                 rise, fall, tick;
    logic [LVL_W:0]       att_sum, dec_diff, rel_diff;
    logic [IN_W+LVL_W-1:0] product;

    assign rise = note_on_i & ~gate_q;
    assign fall = ~note_on_i & gate_q;
    assign tick = (presc_cnt_q == presc_i);

    // One extra bit catches attack overflow and decay/release underflow.
    assign att_sum  = {1'b0, level_q} + {1'b0, attack_step_i};
    assign dec_diff = {1'b0, level_q} - {1'b0, decay_step_i};
    assign rel_diff = {1'b0, level_q} - {1'b0, release_step_i};

    assign product      = {{LVL_W{1'b0}}, sample_in_i} * {{IN_W{1'b0}}, level_q};
    assign sample_out_d = OUT_W'(product >> (LVL_W - 4));

    always_comb begin
        stage_d    = stage_q;
        level_d    = level_q;
        env_done_d = 1'b0;
        if (rise) begin
            stage_d = StAttack;
        end else if (fall && (stage_q inside {StAttack, StDecay, StSustain})) begin
            stage_d = StRelease;
        end else begin
            case (stage_q)
                StIdle: level_d = '0;
                StAttack: begin
                    if (level_q == LvlMax) begin
                        stage_d = StDecay;
                    end else if (tick) begin
                        if (attack_step_i == '0 || att_sum[LVL_W]) level_d = LvlMax;
                        else                                       level_d = att_sum[LVL_W-1:0];
                    end
                end
                StDecay: begin
                    if (level_q <= sustain_level_i) begin
                        stage_d = StSustain;
                    end else if (tick) begin
                        if (decay_step_i == '0 || dec_diff[LVL_W] ||
                            dec_diff[LVL_W-1:0] < sustain_level_i) begin
                            level_d = sustain_level_i;
                        end else begin
                            level_d = dec_diff[LVL_W-1:0];
                        end
                    end
                end
                StSustain: level_d = sustain_level_i;
                StRelease: begin
                    if (level_q == '0) begin
                        stage_d    = StIdle;
                        env_done_d = 1'b1;
                    end else if (tick) begin
                        if (release_step_i == '0 || rel_diff[LVL_W]) level_d = '0;
                        else                                         level_d = rel_diff[LVL_W-1:0];
                    end
                end
                default: begin
                    stage_d = StIdle;
                    level_d = '0;
                end
            endcase
        end
    end

    // Every edge or stage change restarts the tick period from zero.
    always_comb begin
        presc_cnt_d = presc_cnt_q + 1'b1;
        if (rise || fall || (stage_d != stage_q) || tick) begin
            presc_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q      <= StIdle;
            level_q      <= '0;
            presc_cnt_q  <= '0;
            gate_q       <= 1'b0;
            env_done_q   <= 1'b0;
            sample_out_q <= '0;
        end else begin
            stage_q      <= stage_d;
            level_q      <= level_d;
            presc_cnt_q  <= presc_cnt_d;
            gate_q       <= note_on_i;
            env_done_q   <= env_done_d;
            sample_out_q <= sample_out_d;
        end
    end

    assign sample_out_o = sample_out_q;
    assign env_level_o  = level_q;
    assign stage_o      = stage_q;
    assign active_o     = (stage_q != StIdle);
    assign env_done_o   = env_done_q;

endmodule
